// File: rtl/seq_alu_if.sv
// ============================================================================
// Module   : seq_alu_if
// Brief    : Request/response bundle between the seq_alu and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             dz;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, dz, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, ovf, dz, busy
    );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU; single-cycle logic/add/sub, iterative mul/div/rem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    seq_alu_if.slave  bus
);
    localparam int C_CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_MUL = 3'b010;
    localparam logic [2:0] C_OP_DIV = 3'b011;
    localparam logic [2:0] C_OP_REM = 3'b100;
    localparam logic [2:0] C_OP_AND = 3'b101;
    localparam logic [2:0] C_OP_OR  = 3'b110;
    localparam logic [2:0] C_OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_result;
    logic                 r_ovf;
    logic                 r_dz;

    logic                 w_accept;
    logic                 w_iter_op;
    logic                 w_last;
    logic [WIDTH:0]       w_add;
    logic [WIDTH-1:0]     w_sub;
    logic                 w_sub_ovf;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_ext;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_rem_new;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_iter_op = (bus.op == C_OP_MUL) || (bus.op == C_OP_DIV) || (bus.op == C_OP_REM);
    assign w_last    = (r_cnt == C_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_next_state = w_iter_op ? ST_CALC : ST_DONE;
            ST_CALC: if (w_last)        w_next_state = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_add     = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub     = bus.a - bus.b;
    assign w_sub_ovf = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (w_sub[WIDTH-1] ^ bus.a[WIDTH-1]);

    // Shift-add multiply: r_acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: r_acc = {partial remainder, dividend/quotient bits}.
    // A zero divisor always "fits", giving an all-ones quotient and remainder = a.
    assign w_rem_ext  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_rem_ext - {1'b0, r_b};
    assign w_div_ge   = ~w_div_diff[WIDTH] || (r_b == {WIDTH{1'b0}});
    assign w_rem_new  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_rem_ext[WIDTH-1:0];
    assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_b   <= bus.b;
            r_cnt <= C_CNT_W'(WIDTH);
            r_acc <= {{WIDTH{1'b0}}, bus.a};
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
            case (bus.op)
                C_OP_ADD: begin r_result <= w_add[WIDTH-1:0]; r_ovf <= w_add[WIDTH]; end
                C_OP_SUB: begin r_result <= w_sub;            r_ovf <= w_sub_ovf;    end
                C_OP_AND: r_result <= bus.a & bus.b;
                C_OP_OR:  r_result <= bus.a | bus.b;
                C_OP_XOR: r_result <= bus.a ^ bus.b;
                default:  r_result <= r_result;
            endcase
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt - C_CNT_W'(1);
            r_acc <= (r_op == C_OP_MUL) ? w_mul_next : w_div_next;
            if (w_last) begin
                case (r_op)
                    C_OP_MUL: begin
                        r_result <= w_mul_next[WIDTH-1:0];
                        r_ovf    <= |w_mul_next[2*WIDTH-1:WIDTH];
                    end
                    C_OP_DIV: begin
                        r_result <= w_div_next[WIDTH-1:0];
                        r_dz     <= (r_b == {WIDTH{1'b0}});
                    end
                    default: begin
                        r_result <= w_div_next[2*WIDTH-1:WIDTH];
                        r_dz     <= (r_b == {WIDTH{1'b0}});
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign bus.dz        = r_dz;

endmodule

`default_nettype wire
